card_game_ctrl: RTL and testbench
=================================

Name: card_game_ctrl

Overview:
- Top-level game sequencer for the 16-card / 8-pair memory game.
- Pulses the shuffle generator's start, waits for its done, and latches the 48-bit symbol map.
- Accepts player card selections, runs a two-flip compare with a timed reveal, and tracks matched cards, move count and win.
- Sits between the input/debounce logic and the display renderer.

Parameters:
SHOW_CYCLES, 25000000, cycles a mismatched pair stays face-up before hiding (>=1)
TMR_W, 25, width of reveal timer; must hold SHOW_CYCLES-1
MOVES_W, 8, width of move counter

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
new_game  in  1  one-cycle request to (re)start a game
rand_start  out  1  one-cycle start pulse to shuffle generator
rand_done  in  1  one-cycle done from shuffle generator; map valid that cycle
rand_map  in  [0:47]  card i symbol = rand_map[3*i +:3]
sel_valid  in  1  player selects a card this cycle
sel_idx  in  4  selected card index 0-15
sel_ready  out  1  high when selections are accepted (WAIT_FIRST or WAIT_SECOND)
sel_err  out  1  one-cycle pulse: accepted-state selection rejected (card face-up or matched)
map_q  out  [0:47]  latched symbol map
face_up  out  16  bit i = card i currently shown (includes matched)
matched  out  16  bit i = card i permanently matched
moves  out  MOVES_W  completed pair attempts, saturating
game_over  out  1  high in WIN state
busy  out  1  high in SHUFFLE, COMPARE, SHOW

Behaviour:
- Async reset: state=IDLE. All outputs 0: rand_start, sel_ready, sel_err, map_q, face_up, matched, moves, game_over, busy. Internal first/second index regs cleared.
- States: IDLE, SHUFFLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, WIN.
- IDLE: new_game -> rand_start=1 next cycle; go SHUFFLE.
- SHUFFLE entry clears face_up, matched, moves, game_over.
- SHUFFLE: on rand_done, map_q<=rand_map and go WAIT_FIRST. new_game is ignored in SHUFFLE.
- rand_start is exactly one cycle per new_game accepted. rand_done outside SHUFFLE is ignored.
- WAIT_FIRST: sel_valid with card not face-up -> first<=sel_idx, face_up[sel_idx]<=1; go WAIT_SECOND. Face-up card -> sel_err pulse, stay.
- WAIT_SECOND: sel_valid with card not face-up -> second<=sel_idx, face_up set; go COMPARE. Same card as first or any face-up card -> sel_err, stay.
- COMPARE (1 cycle):
  - Increment moves; saturate at all-ones.
  - If map_q[3*first +:3]==map_q[3*second +:3]: set matched[first], matched[second].
    - If matched becomes 16'hFFFF -> WIN, else -> WAIT_FIRST.
  - Else load timer=SHOW_CYCLES-1 and go SHOW.
- SHOW: decrement timer each cycle. At 0, clear face_up[first] and face_up[second]; go WAIT_FIRST. Total reveal = SHOW_CYCLES cycles after COMPARE.
- WIN: game_over=1; face_up stays all-ones.
- sel_valid outside WAIT_FIRST/WAIT_SECOND is ignored, with no sel_err.
- new_game in WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW or WIN: abort immediately, pulse rand_start, go SHUFFLE; the pending compare is discarded.
- new_game has priority over a same-cycle sel_valid.
- Map ordering: card 0 = bits 0..2 (MSB at bit 0 per [0:47] declaration).
- Outputs are registered; no combinational path from sel_* to outputs except sel_ready (state decode).

Test Plan:
- Reset mid-SHOW (resetn low 1 cycle) -> all outputs 0, state IDLE, no rand_start until next new_game.
- new_game, rand_done 5 cycles later with map card0=card5=3'd2, others distinct pairs -> rand_start one pulse; map_q equals rand_map; sel_ready=1 the cycle after rand_done.
- Select 0 then 5 -> face_up=16'h0021, matched=16'h0021, moves=1, back to WAIT_FIRST with no SHOW.
- SHOW_CYCLES=4, select 1 then 2 (mismatch) -> face_up bits 1,2 held 4 cycles after COMPARE then cleared; moves increments by 1; selections in SHOW ignored, sel_err=0.
- Select 0 (matched) in WAIT_FIRST -> sel_err one pulse. Select 3 then 3 -> second select gives sel_err, stays WAIT_SECOND.
- Match all 8 pairs -> game_over=1, matched=16'hFFFF, moves=8. Then new_game -> game_over=0, face_up=0, moves=0, rand_start pulse. Force 300 mismatches -> moves holds 255.

Source files
------------

// File: rtl/card_game_ctrl.sv
// rtl/card_game_ctrl.sv - game sequencer for the 16-card / 8-pair memory game
//
// Sequences shuffle -> two-flip compare -> timed reveal, and tracks matches,
// move count and win.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   new_game           one-cycle request to (re)start a game
//   rand_start         one-cycle start pulse to the shuffle generator
//   rand_done/rand_map shuffle result; card i symbol = rand_map[3*i +:3]
//   sel_valid/sel_idx  player card selection
//   sel_ready          selections accepted (waiting for first/second card)
//   sel_err            one-cycle pulse: selected card already face-up
//   map_q              latched symbol map
//   face_up, matched   per-card shown / permanently matched flags
//   moves              completed pair attempts, saturating
//   game_over          all pairs matched
//   busy               shuffling, comparing or revealing a mismatch
module card_game_ctrl #(
  parameter int SHOW_CYCLES = 25000000,
  parameter int TMR_W       = 25,
  parameter int MOVES_W     = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               new_game,
  output logic               rand_start,
  input  logic               rand_done,
  input  logic [0:47]        rand_map,
  input  logic               sel_valid,
  input  logic [3:0]         sel_idx,
  output logic               sel_ready,
  output logic               sel_err,
  output logic [0:47]        map_q,
  output logic [15:0]        face_up,
  output logic [15:0]        matched,
  output logic [MOVES_W-1:0] moves,
  output logic               game_over,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHUFFLE,
    S_WAIT_FIRST,
    S_WAIT_SECOND,
    S_COMPARE,
    S_SHOW,
    S_WIN
  } state_t;

  localparam logic [TMR_W-1:0]   SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [MOVES_W-1:0] MOVES_MAX = '1;

  state_t             state;
  logic [3:0]         first_idx;
  logic [3:0]         second_idx;
  logic [TMR_W-1:0]   timer;

  logic [2:0]  first_sym;
  logic [2:0]  second_sym;
  logic [15:0] first_bit;
  logic [15:0] second_bit;
  logic [15:0] sel_bit;
  logic [15:0] pair_matched;

  assign first_sym    = map_q[int'(first_idx) * 3 +: 3];
  assign second_sym   = map_q[int'(second_idx) * 3 +: 3];
  assign first_bit    = 16'd1 << first_idx;
  assign second_bit   = 16'd1 << second_idx;
  assign sel_bit      = 16'd1 << sel_idx;
  assign pair_matched = matched | first_bit | second_bit;

  // Pure state decodes of the state register; no path from sel_* inputs.
  assign sel_ready = (state == S_WAIT_FIRST) || (state == S_WAIT_SECOND);
  assign busy      = (state == S_SHUFFLE) || (state == S_COMPARE) || (state == S_SHOW);
  assign game_over = (state == S_WIN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      rand_start <= 1'b0;
      sel_err    <= 1'b0;
      map_q      <= '0;
      face_up    <= '0;
      matched    <= '0;
      moves      <= '0;
      first_idx  <= '0;
      second_idx <= '0;
      timer      <= '0;
    end else begin
      rand_start <= 1'b0;
      sel_err    <= 1'b0;
      // A restart request wins over everything except an in-flight shuffle,
      // and discards any pending compare or reveal.
      if (new_game && state != S_SHUFFLE) begin
        rand_start <= 1'b1;
        state      <= S_SHUFFLE;
        face_up    <= '0;
        matched    <= '0;
        moves      <= '0;
      end else begin
        case (state)
          S_SHUFFLE: begin
            if (rand_done) begin
              map_q <= rand_map;
              state <= S_WAIT_FIRST;
            end
          end
          S_WAIT_FIRST: begin
            if (sel_valid) begin
              if (face_up[sel_idx]) begin
                sel_err <= 1'b1;
              end else begin
                first_idx <= sel_idx;
                face_up   <= face_up | sel_bit;
                state     <= S_WAIT_SECOND;
              end
            end
          end
          S_WAIT_SECOND: begin
            // The first card is already face-up, so re-picking it is rejected here too.
            if (sel_valid) begin
              if (face_up[sel_idx]) begin
                sel_err <= 1'b1;
              end else begin
                second_idx <= sel_idx;
                face_up    <= face_up | sel_bit;
                state      <= S_COMPARE;
              end
            end
          end
          S_COMPARE: begin
            if (moves != MOVES_MAX) begin
              moves <= moves + 1'b1;
            end
            if (first_sym == second_sym) begin
              matched <= pair_matched;
              state   <= (&pair_matched) ? S_WIN : S_WAIT_FIRST;
            end else begin
              timer <= SHOW_LOAD;
              state <= S_SHOW;
            end
          end
          S_SHOW: begin
            // Timer counts SHOW_CYCLES-1 down to 0, giving SHOW_CYCLES reveal cycles.
            if (timer == '0) begin
              face_up <= face_up & ~(first_bit | second_bit);
              state   <= S_WAIT_FIRST;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_game_ctrl.sv
// tb/tb_card_game_ctrl.sv - randomized self-checking bench for card_game_ctrl
module tb_card_game_ctrl;

  localparam int SHOW = 4;
  localparam int MW   = 8;
  localparam int MAXM = (1 << MW) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          new_game;
  logic          rand_start;
  logic          rand_done;
  logic [0:47]   rand_map;
  logic          sel_valid;
  logic [3:0]    sel_idx;
  logic          sel_ready;
  logic          sel_err;
  logic [0:47]   map_q;
  logic [15:0]   face_up;
  logic [15:0]   matched;
  logic [MW-1:0] moves;
  logic          game_over;
  logic          busy;

  card_game_ctrl #(.SHOW_CYCLES(SHOW), .TMR_W(3), .MOVES_W(MW)) dut (
    .clk(clk), .resetn(resetn), .new_game(new_game), .rand_start(rand_start),
    .rand_done(rand_done), .rand_map(rand_map), .sel_valid(sel_valid),
    .sel_idx(sel_idx), .sel_ready(sel_ready), .sel_err(sel_err), .map_q(map_q),
    .face_up(face_up), .matched(matched), .moves(moves), .game_over(game_over),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Behavioural model: a game is "picking" (0 or 1 card already turned),
  // "judging" one pair, or "revealing" a mismatch for a number of cycles.
  localparam int P_IDLE = 0, P_SHUF = 1, P_PICK = 2, P_JUDGE = 3, P_REVEAL = 4, P_WIN = 5;
  int          m_phase, m_npick, m_a, m_b, m_left, m_moves;
  logic [15:0] m_face, m_match;
  logic        m_rs, m_err;
  int          m_sym[16];
  int          cur_sym[16];

  function automatic logic [0:47] pack_syms(input int s[16]);
    logic [0:47] v;
    logic [2:0]  sb;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      sb = s[i][2:0];
      for (int b = 0; b < 3; b++) v[3 * i + b] = sb[2 - b];  // MSB at lowest index
    end
    return v;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_npick = 0; m_a = 0; m_b = 0; m_left = 0; m_moves = 0;
    m_face = '0; m_match = '0; m_rs = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 16; i++) m_sym[i] = 0;
  endtask

  task automatic model_step();
    m_rs = 1'b0; m_err = 1'b0;
    if (new_game && m_phase != P_SHUF) begin
      m_rs = 1'b1; m_phase = P_SHUF; m_face = '0; m_match = '0; m_moves = 0;
      return;
    end
    case (m_phase)
      P_SHUF: if (rand_done) begin
        for (int i = 0; i < 16; i++) m_sym[i] = cur_sym[i];
        m_phase = P_PICK; m_npick = 0;
      end
      P_PICK: if (sel_valid) begin
        if (m_face[sel_idx]) m_err = 1'b1;
        else begin
          m_face[sel_idx] = 1'b1;
          if (m_npick == 0) begin m_a = sel_idx; m_npick = 1; end
          else begin m_b = sel_idx; m_phase = P_JUDGE; end
        end
      end
      P_JUDGE: begin
        m_moves = (m_moves < MAXM) ? m_moves + 1 : MAXM;
        if (m_sym[m_a] == m_sym[m_b]) begin
          m_match[m_a] = 1'b1; m_match[m_b] = 1'b1;
          m_phase = (m_match == 16'hFFFF) ? P_WIN : P_PICK; m_npick = 0;
        end else begin
          m_left = SHOW; m_phase = P_REVEAL;
        end
      end
      P_REVEAL: begin
        m_left--;
        if (m_left == 0) begin
          m_face[m_a] = 1'b0; m_face[m_b] = 1'b0; m_phase = P_PICK; m_npick = 0;
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rand_start", rand_start, m_rs);
      chk("sel_err", sel_err, m_err);
      chk("sel_ready", sel_ready, m_phase == P_PICK);
      chk("busy", busy, m_phase == P_SHUF || m_phase == P_JUDGE || m_phase == P_REVEAL);
      chk("game_over", game_over, m_phase == P_WIN);
      chk("face_up", face_up, m_face);
      chk("matched", matched, m_match);
      chk("moves", moves, m_moves);
      chk("map_q", map_q, pack_syms(m_sym));
    end
  end

  task automatic cycle(input logic ng, input logic sv, input logic [3:0] si, input logic rd);
    new_game = ng; sel_valid = sv; sel_idx = si; rand_done = rd;
    rand_map = pack_syms(cur_sym);
    @(posedge clk);
    #1;
    model_step();
    new_game = 1'b0; sel_valid = 1'b0; rand_done = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic pick(input int idx);
    cycle(1'b0, 1'b1, 4'(idx), 1'b0);
  endtask

  task automatic pair(input int a, input int b);
    pick(a); pick(b); idle();
  endtask

  task automatic do_reset();
    new_game = 1'b0; sel_valid = 1'b0; rand_done = 1'b0;
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic set_dir_map();
    int s[16] = '{2, 0, 1, 3, 4, 2, 5, 6, 7, 0, 1, 3, 4, 5, 6, 7};
    for (int i = 0; i < 16; i++) cur_sym[i] = s[i];
  endtask

  task automatic rand_map_gen();
    int t, j;
    for (int i = 0; i < 16; i++) cur_sym[i] = i / 2;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = cur_sym[i]; cur_sym[i] = cur_sym[j]; cur_sym[j] = t;
    end
  endtask

  initial begin
    resetn = 1'b0; new_game = 1'b0; sel_valid = 1'b0; sel_idx = '0; rand_done = 1'b0;
    for (int i = 0; i < 16; i++) cur_sym[i] = 0;
    rand_map = '0;
    model_reset();
    chk_en = 1'b1;
    do_reset();
    idle(); idle();
    chk("rst_rand_start", rand_start, 0);
    chk("rst_face_up", face_up, 0);
    chk("rst_moves", moves, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel_ready", sel_ready, 0);

    // Start a game; shuffle completes 5 cycles after the request.
    set_dir_map();
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    chk("start_pulse", rand_start, 1);
    repeat (4) idle();
    chk("start_single", rand_start, 0);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    chk("map_literal", map_q, 48'h40B8AEE0B977);
    chk("ready_after_done", sel_ready, 1);

    pair(0, 5);
    chk("match_face", face_up, 16'h0021);
    chk("match_matched", matched, 16'h0021);
    chk("match_moves", moves, 1);

    // Mismatch with selections thrown at the bench during compare/reveal.
    pick(1); pick(2);
    cycle(1'b0, 1'b1, 4'd7, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 4'd4, 1'b0);
    chk("reveal_held", face_up, 16'h0027);
    chk("reveal_no_err", sel_err, 0);
    cycle(1'b0, 1'b1, 4'd4, 1'b0);
    chk("reveal_cleared", face_up, 16'h0021);
    chk("mismatch_moves", moves, 2);

    pick(0);
    chk("err_matched", sel_err, 1);
    idle();
    chk("err_one_pulse", sel_err, 0);
    pick(3); pick(3);
    chk("err_same", sel_err, 1);
    chk("err_stays_ready", sel_ready, 1);
    pick(11); idle();
    pair(1, 9); pair(2, 10); pair(4, 12); pair(6, 13); pair(7, 14); pair(8, 15);
    chk("win_over", game_over, 1);
    chk("win_matched", matched, 16'hFFFF);
    chk("win_moves", moves, 9);

    // Reset in the middle of a reveal.
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    pick(1); pick(2); idle(); idle();
    do_reset();
    chk("midshow_face", face_up, 0);
    chk("midshow_busy", busy, 0);
    repeat (3) idle();
    chk("midshow_no_start", rand_start, 0);

    // Perfect game, then restart from WIN.
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    pair(0, 5); pair(1, 9); pair(2, 10); pair(3, 11);
    pair(4, 12); pair(6, 13); pair(7, 14); pair(8, 15);
    chk("perfect_moves", moves, 8);
    chk("perfect_over", game_over, 1);
    cycle(1'b1, 1'b0, 4'd0, 1'b0);
    chk("restart_over", game_over, 0);
    chk("restart_face", face_up, 0);
    chk("restart_moves", moves, 0);
    chk("restart_pulse", rand_start, 1);

    // Saturate the move counter.
    cycle(1'b0, 1'b0, 4'd0, 1'b1);
    repeat (300) begin
      pick(1); pick(2);
      repeat (6) idle();
    end
    chk("moves_saturate", moves, 255);

    // Random play, restarts and stray shuffle-done pulses.
    repeat (3000) begin
      logic ng, rd;
      ng = ($urandom_range(0, 199) == 0);
      rd = ($urandom_range(0, 3) == 0);
      if (rd) rand_map_gen();
      cycle(ng, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rd);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
